// File: rtl/arbiter_4_2_rr.sv
// +----------------------------------------------------------------------------+
// | Module      : arbiter_4_2_rr                                               |
// | Description : 4-requester round-robin arbiter with registered binary grant |
// |               index and valid/ready handshake toward a 2-4 decoder stage.  |
// |               Define ARB_LOCK_EN to add the lock (priority hold) input.    |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
`default_nettype none

module arbiter_4_2_rr #(
  parameter logic [1:0] START_PTR = 2'b00
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] req,
  input  logic       grant_ready,
`ifdef ARB_LOCK_EN
  input  logic       lock,
`endif
  output logic       grant_valid,
  output logic [1:0] index
);

  typedef enum logic [0:0] {
    S_IDLE  = 1'b0,
    S_GRANT = 1'b1
  } state_t;

  state_t     r_state;
  logic [1:0] r_ptr;

  logic       w_handshake;
  logic       w_found;
  logic [1:0] w_next_ptr;
  logic [1:0] w_base;
  logic [1:0] w_win;
  logic [1:0] w_cand;
  logic       w_regrant;

  always_comb begin
    w_handshake = (r_state == S_GRANT) && grant_ready;
`ifdef ARB_LOCK_EN
    w_next_ptr  = lock ? r_ptr : index + 2'd1;
    w_regrant   = lock && req[index];
`else
    w_next_ptr  = index + 2'd1;
    w_regrant   = 1'b0;
`endif
    // On a handshake the search already starts from the pointer being written.
    w_base      = w_handshake ? w_next_ptr : r_ptr;
    w_found     = |req;
    w_win       = w_base;
    w_cand      = w_base;
    for (int k = 3; k >= 0; k--) begin
      w_cand = w_base + 2'(k);
      if (req[w_cand]) w_win = w_cand;
    end
    if (w_regrant) w_win = index;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_ptr       <= START_PTR;
      grant_valid <= 1'b0;
      index       <= 2'b00;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_found) begin
            index       <= w_win;
            grant_valid <= 1'b1;
            r_state     <= S_GRANT;
          end
        end
        S_GRANT: begin
          // Without ready the grant is committed; req changes are ignored.
          if (grant_ready) begin
            r_ptr <= w_next_ptr;
            if (w_found) begin
              index <= w_win;
            end else begin
              grant_valid <= 1'b0;
              r_state     <= S_IDLE;
            end
          end
        end
        default: begin
          r_state     <= S_IDLE;
          grant_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_arbiter_4_2_rr.sv
// +----------------------------------------------------------------------------+
// | Module      : tb_arbiter_4_2_rr                                            |
// | Description : Directed self-checking bench for arbiter_4_2_rr.             |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
`default_nettype none

module tb_arbiter_4_2_rr;

  logic       clk;
  logic       rst_n;
  logic [3:0] req;
  logic       grant_ready;
  logic       grant_valid;
  logic [1:0] index;
`ifdef ARB_LOCK_EN
  logic       lock;
`endif

  int vectors;
  int miscompares;

  arbiter_4_2_rr #(.START_PTR(2'b00)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .req         (req),
    .grant_ready (grant_ready),
`ifdef ARB_LOCK_EN
    .lock        (lock),
`endif
    .grant_valid (grant_valid),
    .index       (index)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic ev, input logic [1:0] ei);
    vectors++;
    assert (grant_valid === ev) else begin
      miscompares++;
      $error("FAIL %s grant_valid observed=%b expected=%b", tag, grant_valid, ev);
    end
    vectors++;
    assert (index === ei) else begin
      miscompares++;
      $error("FAIL %s index observed=%0d expected=%0d", tag, index, ei);
    end
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    rst_n       = 1'b0;
    req         = 4'b0000;
    grant_ready = 1'b0;
`ifdef ARB_LOCK_EN
    lock        = 1'b0;
`endif
    tick();
    tick();
    chk("reset", 1'b0, 2'd0);
    rst_n = 1'b1;

    // Full request with ready: rotation 0,1,2,3,0
    req = 4'b1111; grant_ready = 1'b1;
    tick(); chk("rr0", 1'b1, 2'd0);
    tick(); chk("rr1", 1'b1, 2'd1);
    tick(); chk("rr2", 1'b1, 2'd2);
    tick(); chk("rr3", 1'b1, 2'd3);
    tick(); chk("rr4", 1'b1, 2'd0);
    req = 4'b0000;
    tick(); chk("rr_idle", 1'b0, 2'd0);          // ptr now 1

    // Backpressure: grant to 2 held for 5 cycles though req drops
    req = 4'b0100; grant_ready = 1'b0;
    tick(); chk("bp1", 1'b1, 2'd2);
    req = 4'b0000;
    tick(); chk("bp2", 1'b1, 2'd2);
    tick(); chk("bp3", 1'b1, 2'd2);
    tick(); chk("bp4", 1'b1, 2'd2);
    tick(); chk("bp5", 1'b1, 2'd2);
    grant_ready = 1'b1;
    tick(); chk("bp_release", 1'b0, 2'd2);       // ptr now 3

    // Wrap from ptr=3
    req = 4'b0001; grant_ready = 1'b0;
    tick(); chk("wrap0", 1'b1, 2'd0);
    req = 4'b1001; grant_ready = 1'b1;
    tick(); chk("wrap3", 1'b1, 2'd3);
    tick(); chk("wrap0b", 1'b1, 2'd0);
    req = 4'b0000;
    tick(); chk("wrap_idle", 1'b0, 2'd0);        // ptr now 1

    // Idle for 10 cycles
    for (int i = 0; i < 10; i++) begin
      tick(); chk("idle", 1'b0, 2'd0);
    end

    // Sole requester re-granted back-to-back; then ptr=2 with 0011 -> 0
    req = 4'b0010; grant_ready = 1'b1;
    tick(); chk("sole1", 1'b1, 2'd1);
    tick(); chk("sole1b", 1'b1, 2'd1);
    req = 4'b0011;
    tick(); chk("ptr2_0011", 1'b1, 2'd0);
    req = 4'b0100;
    tick(); chk("to2", 1'b1, 2'd2);              // ptr now 1
    grant_ready = 1'b0;
    tick(); chk("hold2", 1'b1, 2'd2);

    // Reset between edges while granting
    rst_n = 1'b0;
    #2;
    chk("async_rst", 1'b0, 2'd0);
    rst_n = 1'b1;
    req = 4'b1111;
    tick(); chk("ptr_after_rst", 1'b1, 2'd0);

`ifdef ARB_LOCK_EN
    req = 4'b0011; lock = 1'b1; grant_ready = 1'b1;
    tick(); chk("lock0a", 1'b1, 2'd0);
    tick(); chk("lock0b", 1'b1, 2'd0);
    lock = 1'b0;
    tick(); chk("unlock1", 1'b1, 2'd1);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

`default_nettype wire
